// File: rtl/cgra_mem_pkg.sv
// cgra_mem_pkg: shared widths and the response-stage record for the scratchpad arbiter
package cgra_mem_pkg;
    localparam int NUM_PORTS  = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W_DEF = 10;
    typedef struct packed {
        logic       valid;
        logic [1:0] port;
        logic       we;
        logic       oob;
    } stage1_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational 4-way round-robin grant starting the search at ptr
//   req : per-port request      ptr : highest-priority port
//   en  : grant permitted        gnt : one-hot grant (zero when en=0 or req=0)
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       en,
    output logic [3:0] gnt
);
    logic [1:0] idx;
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (en && req[idx] && gnt == '0) gnt[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/memory_arbiter_4port_32b.sv
// memory_arbiter_4port_32b: 4-port round-robin front end to a single-cycle 32b scratchpad
//   req/addrN/to_memN/write_rq : upstream requests      gnt : combinational one-hot grant
//   rsp_valid/from_memN        : completion pulse and held read data, two cycles after grant
//   mem_*                      : SRAM command/read-data interface
//   oob_err                    : sticky misaligned / out-of-range flag
module memory_arbiter_4port_32b
    import cgra_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [DATA_W-1:0]    addr0,
    input  logic [DATA_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    addr2,
    input  logic [DATA_W-1:0]    addr3,
    input  logic [DATA_W-1:0]    to_mem0,
    input  logic [DATA_W-1:0]    to_mem1,
    input  logic [DATA_W-1:0]    to_mem2,
    input  logic [DATA_W-1:0]    to_mem3,
    input  logic [3:0]           write_rq,
    output logic [3:0]           gnt,
    output logic [3:0]           rsp_valid,
    output logic [DATA_W-1:0]    from_mem0,
    output logic [DATA_W-1:0]    from_mem1,
    output logic [DATA_W-1:0]    from_mem2,
    output logic [DATA_W-1:0]    from_mem3,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ready,
    output logic                 oob_err
);
    logic [DATA_W-1:0] addr_a   [NUM_PORTS];
    logic [DATA_W-1:0] wdata_a  [NUM_PORTS];
    logic [DATA_W-1:0] from_mem [NUM_PORTS];
    logic [1:0]        rr_ptr;
    logic [1:0]        g;
    logic              xfer;
    logic              oob;
    stage1_t           s1;

    assign addr_a  = '{addr0, addr1, addr2, addr3};
    assign wdata_a = '{to_mem0, to_mem1, to_mem2, to_mem3};
    assign {from_mem3, from_mem2, from_mem1, from_mem0} = {from_mem[3], from_mem[2], from_mem[1], from_mem[0]};

    // Gating with rst_n keeps the SRAM idle while reset is held.
    rr_arbiter_4 u_arb (
        .req (req),
        .ptr (rr_ptr),
        .en  (rst_n & mem_ready),
        .gnt (gnt)
    );

    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_PORTS; i++) if (gnt[i]) g = 2'(i);
    end

    // Out-of-range accesses still complete a transfer but never touch the SRAM.
    assign xfer      = |gnt;
    assign oob       = (|addr_a[g][1:0]) | (|addr_a[g][DATA_W-1:ADDR_W+2]);
    assign mem_en    = xfer & ~oob;
    assign mem_we    = mem_en & write_rq[g];
    assign mem_addr  = addr_a[g][ADDR_W+1:2];
    assign mem_wdata = wdata_a[g];

    // s1 lines up with the SRAM's one-cycle read latency, so mem_rdata is captured
    // alongside the stage-1 record and presented at grant+2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            s1        <= '0;
            rsp_valid <= '0;
            from_mem  <= '{default: '0};
            oob_err   <= 1'b0;
        end else begin
            if (xfer) rr_ptr <= g + 2'd1;
            s1        <= '{valid: xfer, port: g, we: write_rq[g], oob: oob};
            rsp_valid <= s1.valid ? 4'b0001 << s1.port : 4'b0000;
            if (s1.valid && !s1.we) from_mem[s1.port] <= s1.oob ? '0 : mem_rdata;
            if (xfer && oob) oob_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_arbiter_4port_32b.sv
// tb_memory_arbiter_4port_32b: directed and random checks against a transaction-level model
module tb_memory_arbiter_4port_32b;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] addr [4];
    logic [31:0] to_mem [4];
    logic [3:0]  write_rq;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [31:0] fm_dut [4];
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready;
    logic        oob_err;

    memory_arbiter_4port_32b dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
        .to_mem0(to_mem[0]), .to_mem1(to_mem[1]), .to_mem2(to_mem[2]), .to_mem3(to_mem[3]),
        .write_rq(write_rq), .gnt(gnt), .rsp_valid(rsp_valid),
        .from_mem0(fm_dut[0]), .from_mem1(fm_dut[1]), .from_mem2(fm_dut[2]), .from_mem3(fm_dut[3]),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    // SRAM environment: one-cycle read latency, garbage on the bus when not reading.
    logic [31:0] sram [1024];
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
        else mem_rdata <= $urandom;
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    end

    typedef struct {
        bit          v;
        int          port;
        bit          we;
        bit          oob;
        logic [31:0] data;
    } txn_t;

    int          n_pass = 0;
    int          n_total = 0;
    int          ptr = 0;
    logic [31:0] mmem [1024];
    logic [31:0] fm_exp [4];
    bit          oob_exp = 0;
    txn_t        p1, p2;
    logic [3:0]  last_gnt;
    logic        last_en;
    logic [9:0]  last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then advance the model.
    task automatic step();
        int          eg;
        logic [31:0] a;
        bit          ob;
        txn_t        nt;
        #1;
        eg = -1;
        if (rst_n && mem_ready)
            for (int k = 0; k < 4; k++)
                if (eg < 0 && req[(ptr + k) % 4]) eg = (ptr + k) % 4;
        ob = 0;
        nt = '{v: 0, port: 0, we: 0, oob: 0, data: '0};
        last_gnt = gnt; last_en = mem_en; last_addr = mem_addr;
        check("gnt", {28'b0, gnt}, eg < 0 ? 32'd0 : 32'd1 << eg);
        if (eg >= 0) begin
            a  = addr[eg];
            ob = (a[1:0] != 2'b00) || ((a >> 12) != 0);
            check("mem_en", {31'b0, mem_en}, {31'b0, !ob});
            check("mem_we", {31'b0, mem_we}, {31'b0, !ob && write_rq[eg]});
            if (!ob) begin
                check("mem_addr", {22'b0, mem_addr}, (a >> 2) & 32'h3ff);
                if (write_rq[eg]) check("mem_wdata", mem_wdata, to_mem[eg]);
            end
            nt = '{v: 1, port: eg, we: write_rq[eg], oob: ob, data: mmem[(a >> 2) & 32'h3ff]};
        end else begin
            check("mem_en_idle", {31'b0, mem_en}, 32'd0);
            check("mem_we_idle", {31'b0, mem_we}, 32'd0);
        end
        check("rsp_valid", {28'b0, rsp_valid}, p2.v ? 32'd1 << p2.port : 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("from_mem%0d", i), fm_dut[i], fm_exp[i]);
        check("oob_err", {31'b0, oob_err}, {31'b0, oob_exp});
        @(posedge clk);
        if (!rst_n) begin
            ptr = 0; p1.v = 0; p2.v = 0; oob_exp = 0;
            for (int i = 0; i < 4; i++) fm_exp[i] = '0;
        end else begin
            p2 = p1;
            if (p2.v && !p2.we) fm_exp[p2.port] = p2.oob ? 32'd0 : p2.data;
            p1 = nt;
            if (nt.v) begin
                ptr = (nt.port + 1) % 4;
                if (nt.oob) oob_exp = 1;
                else if (nt.we) mmem[(a >> 2) & 32'h3ff] = to_mem[nt.port];
            end
        end
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d, input bit w);
        addr[p] = a; to_mem[p] = d; write_rq[p] = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom; sram[i] = v; mmem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            fm_exp[i] = '0; set_port(i, '0, '0, 0);
        end
        p1 = '{v: 0, port: 0, we: 0, oob: 0, data: '0};
        p2 = p1;
        rst_n = 1'b0; req = '0; mem_ready = 1'b1;
        @(negedge clk);
        // Reset holds grants low even with requests pending.
        req = 4'b1111;
        step();
        check("gnt_in_reset", {28'b0, last_gnt}, 32'd0);
        do_reset();

        // Port 1 write then read of byte 0x10.
        req = 4'b0010; set_port(1, 32'h10, 32'hDEADBEEF, 1);
        step();
        check("wr_addr", {22'b0, last_addr}, 32'd4);
        set_port(1, 32'h10, 32'h0, 0);
        step();
        check("rd_addr", {22'b0, last_addr}, 32'd4);
        req = '0;
        step();
        step();
        check("rd_after_wr", fm_dut[1], 32'hDEADBEEF);

        // Full load rotates 0,1,2,3,0,1,2,3 from a fresh pointer.
        do_reset();
        for (int i = 0; i < 4; i++) set_port(i, 32'(i * 4), 32'(i), 0);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_seq", {28'b0, last_gnt}, 32'd1 << (i % 4));
        end

        // Stall cycle holds the pointer.
        req = 4'b0101;
        step();
        check("stall_g0", {28'b0, last_gnt}, 32'd1);
        mem_ready = 1'b0;
        step();
        check("stall_none", {28'b0, last_gnt}, 32'd0);
        mem_ready = 1'b1;
        step();
        check("stall_g2", {28'b0, last_gnt}, 32'd4);
        req = '0;
        step();
        step();

        // Misaligned read on port 3.
        req = 4'b1000; set_port(3, 32'h1002, 32'h0, 0);
        step();
        check("oob_mem_en", {31'b0, last_en}, 32'd0);
        req = '0;
        step();
        step();
        check("oob_from_mem3", fm_dut[3], 32'd0);
        check("oob_sticky", {31'b0, oob_err}, 32'd1);
        step();
        check("oob_still", {31'b0, oob_err}, 32'd1);

        // Reset one cycle after a port 0 read drops the response.
        do_reset();
        req = 4'b0001; set_port(0, 32'h40, 32'h0, 0);
        step();
        req = '0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("drop_rsp", {28'b0, rsp_valid}, 32'd0);
        check("drop_fm0", fm_dut[0], 32'd0);
        req = 4'b1111;
        step();
        check("ptr_after_rst", {28'b0, last_gnt}, 32'd1);
        req = '0;
        step();
        step();

        // Port 2 read then write: read data survives the write's completion.
        v = mmem[8];
        req = 4'b0100; set_port(2, 32'h20, 32'h0, 0);
        step();
        set_port(2, 32'h20, 32'h12345678, 1);
        step();
        req = '0;
        step();
        step();
        step();
        check("hold_fm2", fm_dut[2], v);

        // Random traffic, including stalls, misaligned/high addresses and occasional reset.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            req = 4'($urandom);
            write_rq = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 19))
                    0: addr[i] = {20'h0, 10'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                    1: addr[i] = 32'h1000 | ($urandom & 32'hffff_fffc);
                    default: addr[i] = {20'h0, 10'($urandom_range(0, 15)), 2'b00};
                endcase
                to_mem[i] = $urandom;
            end
            step();
        end
        rst_n = 1'b1; req = '0;
        step();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
